spart_bus_driver: RTL and testbench
===================================

# spart_bus_driver

Bus-side controller for the SPART UART. It programs the baud rate generator's 16-bit divisor through the shared 8-bit I/O bus after reset and whenever the baud select changes. It then runs an echo loop: each received byte is read from the receive buffer and written back to the transmit buffer once the transmitter is free. It sits between board switches and the SPART register interface (ioaddr 00 = RX/TX buffer, 01 = status, 10 = divisor low, 11 = divisor high).

## Interface
Parameters:
- none; the divisor table is fixed for a 50 MHz clk.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- br_cfg  in  2  baud select: 00=4800, 01=9600, 10=19200, 11=38400
- rda  in  1  SPART receive data available
- tbr  in  1  SPART transmit buffer ready
- data_in  in  8  bus read data, valid during a read cycle
- iocs  out  1  SPART chip select; held high in every state except INIT
- iorw  out  1  1 = read, 0 = write
- ioaddr  out  2  register address
- data_out  out  8  bus write data
- data_oe  out  1  drive enable for data_out onto the tristate bus
- rx_byte  out  8  last byte read from the RX buffer
- echo_count  out  8  number of completed TX writes, wraps 255 -> 0

## Operation
- Divisor table:
  - 00 -> 0x028A
  - 01 -> 0x0145
  - 10 -> 0x00A2
  - 11 -> 0x0050
- Moore FSM with outputs decoded from the state register, plus registers cfg_q[1:0], rx_byte and echo_count.
- Default bus outputs (idle): iocs=1, iorw=1, ioaddr=01, data_oe=0, data_out=0. This is a harmless status read and never a divisor write.
- States and outputs:
  - INIT: iocs=0, other outputs at idle values. Reset state. Goes to CFG_LO unconditionally.
  - CFG_LO: iorw=0, ioaddr=10, data_oe=1, data_out=divisor[7:0] of cfg_q. Goes to CFG_HI.
  - CFG_HI: iorw=0, ioaddr=11, data_oe=1, data_out=divisor[15:8]. Goes to IDLE.
  - IDLE: idle bus outputs. Transitions:
    - if br_cfg != cfg_q: load cfg_q <= br_cfg and go to CFG_LO.
    - else if rda: go to RX_RD.
    - else stay in IDLE.
  - RX_RD: iorw=1, ioaddr=00, data_oe=0. Latch rx_byte <= data_in on the exiting edge. Goes to TX_WAIT.
  - TX_WAIT: idle bus outputs. Goes to TX_WR when tbr=1, otherwise stays.
  - TX_WR: iorw=0, ioaddr=00, data_oe=1, data_out=rx_byte. echo_count increments on the exiting edge. Goes to IDLE.
- cfg_q loads br_cfg on the INIT -> CFG_LO edge and on the IDLE reprogram edge only.
- A br_cfg change while in RX_RD, TX_WAIT or TX_WR is deferred until the next IDLE. An in-progress echo always completes first.
- Priority in IDLE: reprogram beats rda.
- rda is ignored outside IDLE. A byte arriving during TX_WAIT is read on the next IDLE visit.
- data_oe is 1 only in CFG_LO, CFG_HI and TX_WR.
- A write strobe (iorw=0) lasts exactly one cycle, and only with ioaddr 10, 11 or 00.

## Timing
- Reset values:
  - state = INIT, cfg_q = 00, rx_byte = 0x00, echo_count = 0x00.
  - Outputs during reset: iocs=0, iorw=1, ioaddr=01, data_oe=0, data_out=0x00.
- rst asserted mid-operation forces INIT immediately (asynchronously), including mid-TX_WAIT. No partial write is completed.
- After rst deasserts:
  - edge 1 -> CFG_LO
  - edge 2 -> CFG_HI
  - edge 3 -> IDLE
  - The divisor is fully programmed 2 cycles after leaving INIT.
- Reprogram latency: br_cfg change seen in IDLE at edge N puts the bus in CFG_LO during cycle N+1 and in CFG_HI during cycle N+2. IDLE resumes at N+3.
- Echo latency with tbr=1: rda seen in IDLE at edge N gives RX_RD during N+1, TX_WAIT during N+2 and TX_WR during N+3. IDLE resumes at N+4.
- data_in must be stable at the edge that ends RX_RD.

## Test plan
- Reset release with br_cfg=01: bus shows (ioaddr=10, data_out=0x45, iorw=0), then (11, 0x01, 0), then idle with ioaddr=01 and iocs=1; iocs=0 throughout reset.
- In IDLE with rda=1, data_in=0x5A and tbr=1: one read cycle at ioaddr 00, then a write cycle at 00 with data_out=0x5A three cycles after rda is sampled; rx_byte=0x5A, echo_count=1.
- tbr held 0 for 10 cycles after RX_RD: FSM stays in TX_WAIT with no write strobe and data_oe=0; tbr=1 produces exactly one TX_WR.
- br_cfg changed 01->11 during TX_WAIT: the echo completes first, then CFG_LO writes 0x50 and CFG_HI writes 0x00; rda asserted in the same IDLE cycle is serviced after reprogramming.
- rst pulsed during TX_WAIT: outputs return to reset values immediately; no TX write occurs; full divisor reprogram follows release.
- 256 back-to-back echoes: echo_count wraps to 0x00.

Source files
------------

// File: rtl/spart_bus_driver.sv
// spart_bus_driver
//   Bus-side controller for the SPART UART. After reset, and whenever br_cfg
//   changes while idle, it writes the 16-bit baud divisor (low byte, then high
//   byte) over the 8-bit I/O bus. Otherwise it echoes every received byte:
//   read the RX buffer, wait for the transmitter, write the byte back.
//
// Ports
//   clk, rst     system clock (rising edge), asynchronous active-high reset
//   br_cfg       baud select (00=4800, 01=9600, 10=19200, 11=38400)
//   rda, tbr     SPART receive-data-available / transmit-buffer-ready
//   data_in      bus read data, sampled at the edge that ends the RX read
//   iocs         chip select, low only in INIT
//   iorw         1 = read, 0 = write
//   ioaddr       register address (00 buffer, 01 status, 10/11 divisor lo/hi)
//   data_out     bus write data, data_oe enables it onto the tristate bus
//   rx_byte      last byte read from the RX buffer
//   echo_count   completed TX writes, wraps 255 -> 0
module spart_bus_driver (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    input  logic       rda,
    input  logic       tbr,
    input  logic [7:0] data_in,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic [7:0] rx_byte,
    output logic [7:0] echo_count
);

    typedef enum logic [2:0] {
        StInit,
        StCfgLo,
        StCfgHi,
        StIdle,
        StRxRd,
        StTxWait,
        StTxWr
    } state_e;

    // Divisors for a 50 MHz clock.
    function automatic logic [15:0] divisor(input logic [1:0] sel);
        logic [15:0] d;
        case (sel)
            2'b00:   d = 16'h028A;
            2'b01:   d = 16'h0145;
            2'b10:   d = 16'h00A2;
            default: d = 16'h0050;
        endcase
        return d;
    endfunction

    state_e      state_q, state_d;
    logic [1:0]  cfg_q, cfg_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic [7:0]  echo_cnt_q, echo_cnt_d;

    logic        iocs_q, iocs_d;
    logic        iorw_q, iorw_d;
    logic [1:0]  ioaddr_q, ioaddr_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        data_oe_q, data_oe_d;
    logic [15:0] div_d;

    // Next state and datapath registers.
    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        rx_byte_d  = rx_byte_q;
        echo_cnt_d = echo_cnt_q;
        unique case (state_q)
            StInit: begin
                cfg_d   = br_cfg;
                state_d = StCfgLo;
            end
            StCfgLo: state_d = StCfgHi;
            StCfgHi: state_d = StIdle;
            StIdle: begin
                // Reprogramming takes priority over a pending receive byte.
                if (br_cfg != cfg_q) begin
                    cfg_d   = br_cfg;
                    state_d = StCfgLo;
                end else if (rda) begin
                    state_d = StRxRd;
                end
            end
            StRxRd: begin
                rx_byte_d = data_in;
                state_d   = StTxWait;
            end
            StTxWait: begin
                if (tbr) begin
                    state_d = StTxWr;
                end
            end
            StTxWr: begin
                echo_cnt_d = echo_cnt_q + 8'd1;
                state_d    = StIdle;
            end
            default: state_d = StInit;
        endcase
    end

    // Bus outputs are decoded from the next state so they come straight out
    // of flops while still matching the state they belong to.
    always_comb begin
        div_d      = divisor(cfg_d);
        iocs_d     = 1'b1;
        iorw_d     = 1'b1;
        ioaddr_d   = 2'b01;
        data_out_d = 8'h00;
        data_oe_d  = 1'b0;
        unique case (state_d)
            StInit: iocs_d = 1'b0;
            StCfgLo: begin
                iorw_d     = 1'b0;
                ioaddr_d   = 2'b10;
                data_oe_d  = 1'b1;
                data_out_d = div_d[7:0];
            end
            StCfgHi: begin
                iorw_d     = 1'b0;
                ioaddr_d   = 2'b11;
                data_oe_d  = 1'b1;
                data_out_d = div_d[15:8];
            end
            StRxRd: ioaddr_d = 2'b00;
            StTxWr: begin
                iorw_d     = 1'b0;
                ioaddr_d   = 2'b00;
                data_oe_d  = 1'b1;
                data_out_d = rx_byte_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StInit;
            cfg_q      <= 2'b00;
            rx_byte_q  <= 8'h00;
            echo_cnt_q <= 8'h00;
            iocs_q     <= 1'b0;
            iorw_q     <= 1'b1;
            ioaddr_q   <= 2'b01;
            data_out_q <= 8'h00;
            data_oe_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            rx_byte_q  <= rx_byte_d;
            echo_cnt_q <= echo_cnt_d;
            iocs_q     <= iocs_d;
            iorw_q     <= iorw_d;
            ioaddr_q   <= ioaddr_d;
            data_out_q <= data_out_d;
            data_oe_q  <= data_oe_d;
        end
    end

    assign iocs       = iocs_q;
    assign iorw       = iorw_q;
    assign ioaddr     = ioaddr_q;
    assign data_out   = data_out_q;
    assign data_oe    = data_oe_q;
    assign rx_byte    = rx_byte_q;
    assign echo_count = echo_cnt_q;

endmodule

// File: tb/tb_spart_bus_driver.sv
// tb_spart_bus_driver
//   Directed bench for spart_bus_driver. Every expected bus write (address,
//   data) is queued when the stimulus that causes it is driven; a monitor pops
//   and compares on each observed write strobe. Directed checks cover reset
//   values, idle/read cycles, TX_WAIT stalls and counters.
module tb_spart_bus_driver;

    logic       clk;
    logic       rst;
    logic [1:0] br_cfg;
    logic       rda;
    logic       tbr;
    logic [7:0] data_in;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic [7:0] data_out;
    logic       data_oe;
    logic [7:0] rx_byte;
    logic [7:0] echo_count;

    int checks   = 0;
    int failures = 0;

    logic [9:0] exp_q[$];  // {ioaddr, data_out} of expected writes, in order

    spart_bus_driver dut (
        .clk        (clk),
        .rst        (rst),
        .br_cfg     (br_cfg),
        .rda        (rda),
        .tbr        (tbr),
        .data_in    (data_in),
        .iocs       (iocs),
        .iorw       (iorw),
        .ioaddr     (ioaddr),
        .data_out   (data_out),
        .data_oe    (data_oe),
        .rx_byte    (rx_byte),
        .echo_count (echo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b0 && iorw === 1'b0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {4'h0, data_oe, 1'b0, ioaddr, data_out}, 16'hFFFF);
            end else begin
                check("bus_write", {4'h0, data_oe, 1'b0, ioaddr, data_out},
                      {4'h0, 1'b1, 1'b0, exp_q.pop_front()});
            end
        end
    end

    task automatic check_idle(input string tag);
        check(tag, {iocs, iorw, ioaddr, data_oe, 3'b000, data_out}, {1'b1, 1'b1, 2'b01, 1'b0, 3'b000, 8'h00});
    endtask

    // Bounded wait for the RX buffer read cycle (read at address 00).
    task automatic wait_rx_rd();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(iorw === 1'b1 && ioaddr === 2'b00) && n < 20);
        check("rx_rd_seen", {15'h0, (iorw === 1'b1 && ioaddr === 2'b00)}, 16'h1);
    endtask

    initial begin
        rst     = 1'b1;
        br_cfg  = 2'b01;
        rda     = 1'b0;
        tbr     = 1'b0;
        data_in = 8'h00;

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_bus", {iocs, iorw, ioaddr, data_oe, 3'b000, data_out}, {1'b0, 1'b1, 2'b01, 1'b0, 3'b000, 8'h00});
        check("rst_rx_byte", {8'h0, rx_byte}, 16'h0000);
        check("rst_echo_count", {8'h0, echo_count}, 16'h0000);

        // Release with 9600 baud: divisor 0x0145.
        exp_q.push_back({2'b10, 8'h45});
        exp_q.push_back({2'b11, 8'h01});
        rst = 1'b0;
        @(negedge clk);
        check("cfg_lo_addr", {14'h0, ioaddr}, 16'h0002);
        check("cfg_lo_iocs", {15'h0, iocs}, 16'h0001);
        @(negedge clk);
        check("cfg_hi_addr", {14'h0, ioaddr}, 16'h0003);
        @(negedge clk);
        check_idle("idle_after_cfg");

        // Single echo with tbr ready.
        rda = 1'b1; data_in = 8'h5A; tbr = 1'b1;
        exp_q.push_back({2'b00, 8'h5A});
        @(negedge clk);
        check("echo_rx_rd", {iorw, ioaddr, data_oe}, {1'b1, 2'b00, 1'b0});
        rda = 1'b0;
        @(negedge clk);
        check_idle("echo_tx_wait");
        @(negedge clk);
        check("echo_tx_wr_rx_byte", {8'h0, rx_byte}, 16'h005A);
        @(negedge clk);
        check_idle("echo_back_idle");
        check("echo_count_1", {8'h0, echo_count}, 16'h0001);

        // TX_WAIT stall: no write while tbr is low.
        tbr = 1'b0; rda = 1'b1; data_in = 8'hC3;
        exp_q.push_back({2'b00, 8'hC3});
        wait_rx_rd();
        rda = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_no_write", {14'h0, iorw, data_oe}, 16'h0002);
        end
        tbr = 1'b1;
        @(negedge clk);
        check("stall_tx_wr", {iorw, ioaddr, data_oe}, {1'b0, 2'b00, 1'b1});
        @(negedge clk);
        check_idle("stall_back_idle");
        check("echo_count_2", {8'h0, echo_count}, 16'h0002);

        // br_cfg change in TX_WAIT: echo first, then reprogram, then the new byte.
        tbr = 1'b0; rda = 1'b1; data_in = 8'h11;
        exp_q.push_back({2'b00, 8'h11});
        exp_q.push_back({2'b10, 8'h50});
        exp_q.push_back({2'b11, 8'h00});
        exp_q.push_back({2'b00, 8'h22});
        wait_rx_rd();
        rda = 1'b0;
        @(negedge clk);
        br_cfg = 2'b11;
        @(negedge clk);
        check("defer_still_wait", {14'h0, iorw, data_oe}, 16'h0002);
        tbr = 1'b1;
        @(negedge clk);
        rda = 1'b1; data_in = 8'h22;
        @(negedge clk);
        check_idle("defer_idle");
        @(negedge clk);
        check("defer_cfg_lo", {14'h0, ioaddr}, 16'h0002);
        wait_rx_rd();
        rda = 1'b0;
        repeat (3) @(negedge clk);
        check("echo_count_4", {8'h0, echo_count}, 16'h0004);
        check("rx_byte_22", {8'h0, rx_byte}, 16'h0022);

        // Reset pulsed mid TX_WAIT: no write, full reprogram afterwards.
        tbr = 1'b0; rda = 1'b1; data_in = 8'h77;
        wait_rx_rd();
        rda = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_bus", {iocs, iorw, ioaddr, data_oe, 3'b000, data_out}, {1'b0, 1'b1, 2'b01, 1'b0, 3'b000, 8'h00});
        check("async_rst_count", {8'h0, echo_count}, 16'h0000);
        check("async_rst_rx_byte", {8'h0, rx_byte}, 16'h0000);
        tbr = 1'b1;
        repeat (2) @(negedge clk);
        exp_q.push_back({2'b10, 8'h50});
        exp_q.push_back({2'b11, 8'h00});
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("post_rst_idle");
        check("post_rst_count", {8'h0, echo_count}, 16'h0000);

        // 256 back-to-back echoes wrap the counter.
        for (int i = 0; i < 256; i++) begin
            rda = 1'b1;
            data_in = 8'(i);
            exp_q.push_back({2'b00, 8'(i)});
            wait_rx_rd();
            rda = 1'b0;
            repeat (3) @(negedge clk);
            if (i == 254) check("echo_count_255", {8'h0, echo_count}, 16'h00FF);
        end
        check("echo_count_wrap", {8'h0, echo_count}, 16'h0000);
        check("rx_byte_last", {8'h0, rx_byte}, 16'h00FF);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 16'(exp_q.size()), 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
